// File: rtl/add_sub_pkg.sv
// Shared types for the add_sub self-test engine: FSM states and sweep sizing.
package add_sub_pkg;

    typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;

    localparam int unsigned DEF_N = 4;

    // Every (A, B, Sel) combination for an n-bit datapath.
    function automatic int unsigned num_vec(int unsigned n);
        return 32'd1 << (2 * n + 1);
    endfunction

    localparam int unsigned NUM_VEC = num_vec(DEF_N);

endpackage

// File: rtl/add_sub_ref.sv
// Combinational golden model of add_sub: subtract is A + ~B + 1, so Co = 1 means no borrow.
module add_sub_ref #(
    parameter int N = 4
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Sel,
    output logic [N-1:0] S_exp,
    output logic         Co_exp,
    output logic         Ov_exp
);

    logic [N-1:0] bx;
    logic [N:0]   r;

    assign bx     = Sel ? ~B : B;
    assign r      = {1'b0, A} + {1'b0, bx} + {{N{1'b0}}, Sel};
    assign S_exp  = r[N-1:0];
    assign Co_exp = r[N];
    // Overflow: effective operands share a sign but the result's sign differs.
    assign Ov_exp = (A[N-1] == bx[N-1]) && (S_exp[N-1] != A[N-1]);

endmodule

// File: rtl/add_sub_bist.sv
// Sweeps all (A, B, Sel) vectors into an add_sub datapath and checks each result
// against add_sub_ref, reporting pass/fail, a saturating error count and the first failing vector.
module add_sub_bist
    import add_sub_pkg::*;
#(
    parameter int N      = 4,
    parameter int SETTLE = 2,
    parameter int ERR_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [N-1:0]     A,
    output logic [N-1:0]     B,
    output logic             Sel,
    input  logic [N-1:0]     S,
    input  logic             Co,
    input  logic             Ov,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             fail_valid,
    output logic [2*N:0]     fail_vec
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [N-1:0]    s_exp;
    logic            co_exp, ov_exp;
    logic            mismatch, last_vec;
    logic [ERR_W-1:0] err_nxt;

    add_sub_ref #(.N(N)) u_ref (
        .A      (A),
        .B      (B),
        .Sel    (Sel),
        .S_exp  (s_exp),
        .Co_exp (co_exp),
        .Ov_exp (ov_exp)
    );

    assign mismatch = (S != s_exp) || (Co != co_exp) || (Ov != ov_exp);
    assign last_vec = (&A) && (&B) && Sel;
    assign err_nxt  = (state == CHECK && mismatch && !(&err_count)) ? err_count + 1'b1 : err_count;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = APPLY;
            APPLY:      if (cnt == CW'(SETTLE - 1)) state_nxt = CHECK;
            CHECK:      state_nxt = last_vec ? DONE : APPLY;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            A          <= '0;
            B          <= '0;
            Sel        <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_vec   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        cnt        <= '0;
                        A          <= '0;
                        B          <= '0;
                        Sel        <= 1'b0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        err_count  <= '0;
                        fail_valid <= 1'b0;
                        fail_vec   <= '0;
                    end
                end
                APPLY: cnt <= cnt + 1'b1;
                CHECK: begin
                    cnt       <= '0;
                    err_count <= err_nxt;
                    if (mismatch && !fail_valid) begin
                        fail_valid <= 1'b1;
                        fail_vec   <= {A, B, Sel};
                    end
                    if (last_vec) begin
                        // Final vector stays on the bus through DONE.
                        busy <= 1'b0;
                        done <= 1'b1;
                        pass <= (err_nxt == '0);
                    end else begin
                        Sel <= ~Sel;
                        if (Sel) begin
                            B <= B + 1'b1;
                            if (&B) A <= A + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_add_sub_bist.sv
// Bench for add_sub_bist: behavioural add_sub with fault hooks, table of sweep cases,
// scoreboard of expected vector order, and reset / restart / SETTLE=1 sequences.
module tb_add_sub_bist;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, start1 = 1'b0;
    logic [N-1:0] A, B, S, A1, B1, S1;
    logic Sel, Co, Ov, Sel1, Co1, Ov1;
    logic busy, done, pass, fail_valid, busy1, done1, pass1, fail_valid1;
    logic [7:0] err_count, err_count1;
    logic [2*N:0] fail_vec, fail_vec1;
    logic f_co0 = 1'b0, f_ov0 = 1'b0, f_s0 = 1'b0;

    int n_cmp = 0, n_fail = 0;
    logic [2*N:0] sb_q[$];
    logic mon_en = 1'b0;
    logic prev_busy = 1'b0;
    logic [2*N:0] prev_vec;
    int hold = 0;

    always #5 clk = ~clk;

    // Independent datapath: plain subtraction and sign-rule overflow, returns {S, Co, Ov}.
    function automatic logic [5:0] dp(input logic [3:0] a, input logic [3:0] b, input logic sel);
        logic [4:0] r;
        logic ov;
        if (sel) begin
            r  = {1'b0, a} - {1'b0, b};
            r[4] = (a >= b);
            ov = (a[3] != b[3]) && (r[3] != a[3]);
        end else begin
            r  = {1'b0, a} + {1'b0, b};
            ov = (a[3] == b[3]) && (r[3] != a[3]);
        end
        return {r[3:0], r[4], ov};
    endfunction

    always_comb begin
        {S, Co, Ov} = dp(A, B, Sel);
        if (f_co0) Co = 1'b0;
        if (f_ov0) Ov = 1'b0;
        if (f_s0)  S[0] = 1'b0;
        {S1, Co1, Ov1} = dp(A1, B1, Sel1);
    end

    add_sub_bist #(.N(N), .SETTLE(2), .ERR_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .Sel(Sel),
        .S(S), .Co(Co), .Ov(Ov), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .fail_valid(fail_valid), .fail_vec(fail_vec)
    );

    add_sub_bist #(.N(N), .SETTLE(1), .ERR_W(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .A(A1), .B(B1), .Sel(Sel1),
        .S(S1), .Co(Co1), .Ov(Ov1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err_count1), .fail_valid(fail_valid1), .fail_vec(fail_vec1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic fill_sb();
        sb_q.delete();
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int s = 0; s < 2; s++)
                    sb_q.push_back({a[3:0], b[3:0], s[0]});
    endtask

    // Scoreboard: each new vector on the bus must be the next one in sweep order, held 3 cycles.
    always @(negedge clk) begin
        if (mon_en) begin
            if (busy && (!prev_busy || {A, B, Sel} != prev_vec)) begin
                if (prev_busy) chk("vec_hold", hold, 3);
                if (sb_q.size() == 0) chk("sb_underflow", 1, 0);
                else chk("vec_order", {A, B, Sel}, sb_q.pop_front());
                hold = 1;
            end else if (busy) begin
                hold++;
            end else if (prev_busy) begin
                chk("vec_hold_last", hold, 3);
            end
        end
        prev_busy = busy;
        prev_vec  = {A, B, Sel};
    end

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 4000) begin
            @(posedge clk); cyc++;
            @(negedge clk);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_done"}, done, 0);
        chk({nm, "_pass"}, pass, 0);
        chk({nm, "_err"}, err_count, 0);
        chk({nm, "_fvalid"}, fail_valid, 0);
        chk({nm, "_fvec"}, fail_vec, 0);
        chk({nm, "_abs"}, {A, B, Sel}, 0);
    endtask

    typedef struct {
        string      name;
        logic       co0, ov0, s0;
        logic       exp_pass;
        logic [7:0] exp_err;
        logic       exp_fv;
        logic [8:0] exp_fvec;
    } case_t;

    case_t cases[4];
    int cyc;

    initial begin
        cases[0] = '{"clean",  0, 0, 0, 1, 8'd0,   0, 9'h000};
        cases[1] = '{"co_lo",  1, 0, 0, 0, 8'd255, 1, 9'h001};
        cases[2] = '{"ov_lo",  0, 1, 0, 0, 8'd128, 1, 9'h011};
        cases[3] = '{"s0_lo",  0, 0, 1, 0, 8'd255, 1, 9'h002};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("rst");
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            f_co0 = cases[i].co0; f_ov0 = cases[i].ov0; f_s0 = cases[i].s0;
            fill_sb(); mon_en = 1'b1;
            pulse_start();
            wait_done(cyc);
            chk({cases[i].name, "_cycles"}, cyc, 1536);
            chk({cases[i].name, "_busy"}, busy, 0);
            chk({cases[i].name, "_pass"}, pass, cases[i].exp_pass);
            chk({cases[i].name, "_err"}, err_count, cases[i].exp_err);
            chk({cases[i].name, "_fvalid"}, fail_valid, cases[i].exp_fv);
            chk({cases[i].name, "_fvec"}, fail_vec, cases[i].exp_fvec);
            chk({cases[i].name, "_last_vec"}, {A, B, Sel}, 9'h1ff);
            chk({cases[i].name, "_sb_empty"}, sb_q.size(), 0);
            mon_en = 1'b0;
        end
        f_co0 = 1'b0; f_ov0 = 1'b0; f_s0 = 1'b0;

        // Reset midway through a sweep, then a clean full run.
        pulse_start();
        repeat (700) @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        chk_reset_vals("mid_rst");
        fill_sb(); mon_en = 1'b1;
        pulse_start();
        wait_done(cyc);
        chk("post_rst_cycles", cyc, 1536);
        chk("post_rst_pass", pass, 1);
        chk("post_rst_sb_empty", sb_q.size(), 0);
        mon_en = 1'b0;

        // start held high: ignored while busy, restarts right after DONE.
        @(negedge clk); start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("hold_busy", busy, 1);
        wait_done(cyc);
        chk("hold_cycles", cyc, 1536);
        chk("hold_done", done, 1);
        @(posedge clk);
        @(negedge clk);
        chk("hold_done_1cyc", done, 0);
        chk("hold_restart_busy", busy, 1);
        chk("hold_restart_vec", {A, B, Sel}, 0);
        start = 1'b0;
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk); rst_n = 1'b1;

        // SETTLE=1 instance.
        start1 = 1'b1;
        @(posedge clk);
        @(negedge clk); start1 = 1'b0;
        cyc = 0;
        while (!done1 && cyc < 4000) begin
            @(posedge clk); cyc++;
            @(negedge clk);
        end
        chk("s1_cycles", cyc, 1024);
        chk("s1_pass", pass1, 1);
        chk("s1_err", err_count1, 0);
        chk("s1_fvalid", fail_valid1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
